rast_tri_feeder: RTL and testbench

- Drives triangles into the rasterizer input port (tri_R10S, color_R10U, validTri_R10H) and obeys the rasterizer's halt_RnnnnL back-pressure.
- Upstream, a test generator or geometry stage pushes triangles over a valid/ready interface.
- A DEPTH-entry FIFO plus one output register decouples the producer from the rasterizer's stall cycles.
- Keeps a running count of triangles handed off and an idle flag for end-of-test detection.

---
 rtl/rast_tri_feeder.sv | 136 +++++++++++++
 tb/tb_rast_tri_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_tri_feeder.sv
// Rasterizer triangle feeder: skid FIFO plus output register
// honouring the rasterizer halt back-pressure.
module rast_tri_feeder #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  in_tri_S,
  input  logic [COLORS-1:0][SIGFIG-1:0]           in_color_U,
  input  logic                                    in_valid_H,
  output logic                                    in_ready_H,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]           color_R10U,
  output logic                                    validTri_R10H,
  input  logic                                    halt_RnnnnL,
  output logic [31:0]                             tri_count_U,
  output logic                                    idle_H
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RADIX >= SIGFIG)
  begin : g_bad_params
    $error("rast_tri_feeder: bad parameters");
  end

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;
  typedef struct packed {
    tri_t t;
    col_t c;
  } ent_t;

  typedef enum logic {EMPTY, HOLD} st_t;

  st_t         state;
  ent_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   occ;

  logic consume;
  logic slot;
  logic push;
  logic fifo_ne;
  logic pop;
  logic bypass;
  logic wr;

  assign consume = validTri_R10H & halt_RnnnnL;
  assign slot    = ~validTri_R10H | consume;
  assign push    = in_valid_H & in_ready_H;
  assign fifo_ne = (occ != '0);
  assign pop     = slot & fifo_ne;
  assign bypass  = slot & ~fifo_ne & push;
  assign wr      = push & ~bypass;

  assign in_ready_H    = rst & (occ < FULL);
  assign validTri_R10H = (state == HOLD);
  assign idle_H        = ~fifo_ne & ~validTri_R10H;

  // FIFO storage; contents need no reset, pointers gate them
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= '{t: in_tri_S, c: in_color_U};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // output register FSM: load from FIFO head, else bypass input
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      tri_R10S   <= '0;
      color_R10U <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (pop) begin
            tri_R10S   <= mem[rd_ptr].t;
            color_R10U <= mem[rd_ptr].c;
            state      <= HOLD;
          end else if (bypass) begin
            tri_R10S   <= in_tri_S;
            color_R10U <= in_color_U;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (pop) begin
            tri_R10S   <= mem[rd_ptr].t;
            color_R10U <= mem[rd_ptr].c;
          end else if (bypass) begin
            tri_R10S   <= in_tri_S;
            color_R10U <= in_color_U;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // handed-off triangle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      tri_count_U <= '0;
    end else if (consume) begin
      tri_count_U <= tri_count_U + 32'd1;
    end
  end

endmodule

// File: tb/tb_rast_tri_feeder.sv
// Randomized scoreboard bench for rast_tri_feeder.
// Model: queue of accepted, not yet consumed triangles.
module tb_rast_tri_feeder;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 4;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;
  typedef struct packed {
    tri_t t;
    col_t c;
  } ent_t;

  logic clk = 0;
  logic rst = 0;
  tri_t in_tri_S = '0;
  col_t in_color_U = '0;
  logic in_valid_H = 0;
  logic in_ready_H;
  tri_t tri_R10S;
  col_t color_R10U;
  logic validTri_R10H;
  logic halt_RnnnnL = 1;
  logic [31:0] tri_count_U;
  logic idle_H;

  rast_tri_feeder #(
    .SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS),
    .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_tri_S(in_tri_S), .in_color_U(in_color_U),
    .in_valid_H(in_valid_H), .in_ready_H(in_ready_H),
    .tri_R10S(tri_R10S), .color_R10U(color_R10U),
    .validTri_R10H(validTri_R10H),
    .halt_RnnnnL(halt_RnnnnL),
    .tri_count_U(tri_count_U), .idle_H(idle_H)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit armed = 0;
  ent_t q[$];
  logic [31:0] exp_count = 0;

  task automatic chk(input string nm, input bit ok,
                     input logic [319:0] act,
                     input logic [319:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        e.t[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++)
      e.c[c] = SIGFIG'($urandom);
    return e;
  endfunction

  function automatic ent_t mk_t0();
    ent_t e;
    e = '0;
    e.t[0][0] = 24'h400;
    e.t[0][1] = 24'h400;
    e.t[1][0] = 24'hC00;
    e.t[2][1] = 24'hFFF800;
    for (int c = 0; c < COLORS; c++) e.c[c] = 24'hFFF;
    return e;
  endfunction

  // monitor: compare against model, then advance model
  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        chk("in_ready", in_ready_H == (q.size() <= DEPTH),
            320'(in_ready_H), 320'(q.size() <= DEPTH));
        chk("valid", validTri_R10H == (q.size() > 0),
            320'(validTri_R10H), 320'(q.size() > 0));
        chk("idle", idle_H == (q.size() == 0),
            320'(idle_H), 320'(q.size() == 0));
        chk("count", tri_count_U == exp_count,
            320'(tri_count_U), 320'(exp_count));
        if (q.size() > 0)
          chk("front", {tri_R10S, color_R10U} == q[0],
              320'({tri_R10S, color_R10U}), 320'(q[0]));
      end else begin
        chk("ready_in_rst", in_ready_H == 1'b0,
            320'(in_ready_H), 320'(0));
      end
      if (!rst) begin
        q.delete();
        exp_count = 0;
      end else begin
        if (validTri_R10H && halt_RnnnnL && q.size() > 0) begin
          chk("consume", {tri_R10S, color_R10U} == q[0],
              320'({tri_R10S, color_R10U}), 320'(q[0]));
          void'(q.pop_front());
          exp_count = exp_count + 32'd1;
        end
        if (in_valid_H && in_ready_H)
          q.push_back('{t: in_tri_S, c: in_color_U});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ent_t e);
    bit acc;
    int n;
    in_tri_S   = e.t;
    in_color_U = e.c;
    in_valid_H = 1;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_H;
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 1'b0, 320'(n), 320'(0));
    in_valid_H = 0;
  endtask

  task automatic drain();
    int n;
    halt_RnnnnL = 1;
    in_valid_H = 0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", q.size() == 0, 320'(q.size()), 320'(0));
  endtask

  ent_t tv [6];
  int t_start;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    rst = 0;
    @(posedge clk);
    armed = 1;
    repeat (3) step();
    rst = 1;
    @(negedge clk);
    chk("rst_tri", tri_R10S == '0, 320'(tri_R10S), 320'(0));
    chk("rst_color", color_R10U == '0, 320'(color_R10U), 320'(0));
    chk("rst_ready", in_ready_H == 1'b1, 320'(in_ready_H), 320'(1));
    chk("rst_idle", idle_H == 1'b1, 320'(idle_H), 320'(1));
    step();

    // single triangle, no stall
    send(mk_t0());
    @(negedge clk);
    chk("single_valid", validTri_R10H == 1'b1,
        320'(validTri_R10H), 320'(1));
    step();
    @(negedge clk);
    chk("single_idle", idle_H == 1'b1, 320'(idle_H), 320'(1));
    chk("single_cnt", tri_count_U == 32'd1, 320'(tri_count_U), 320'(1));
    step();

    // stall for 10 cycles
    halt_RnnnnL = 0;
    send(mk_t0());
    repeat (10) step();
    halt_RnnnnL = 1;
    repeat (2) step();
    chk("stall_cnt", tri_count_U == 32'd2, 320'(tri_count_U), 320'(2));

    // fill: DEPTH+1 buffered, then ordered release
    halt_RnnnnL = 0;
    for (int k = 0; k < 6; k++) tv[k] = rnd_ent();
    for (int k = 0; k < 5; k++) send(tv[k]);
    in_tri_S = tv[5].t;
    in_color_U = tv[5].c;
    in_valid_H = 1;
    @(negedge clk);
    chk("fill_ready", in_ready_H == 1'b0, 320'(in_ready_H), 320'(0));
    step();
    halt_RnnnnL = 1;
    for (int k = 0; k < 6; k++) begin
      bit drop;
      @(negedge clk);
      chk("fill_order", validTri_R10H &&
          {tri_R10S, color_R10U} == tv[k],
          320'({tri_R10S, color_R10U}), 320'(tv[k]));
      drop = in_valid_H && in_ready_H;
      step();
      if (drop) in_valid_H = 0;
    end
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ent_t e;
      e = rnd_ent();
      in_tri_S = e.t;
      in_color_U = e.c;
      in_valid_H = ($urandom_range(0, 3) != 0);
      halt_RnnnnL = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // reset mid-operation: 1 in output, 3 queued
    halt_RnnnnL = 0;
    for (int k = 0; k < 4; k++) send(rnd_ent());
    rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    chk("mid_valid", validTri_R10H == 1'b0, 320'(validTri_R10H), 320'(0));
    chk("mid_cnt", tri_count_U == 32'd0, 320'(tri_count_U), 320'(0));
    chk("mid_idle", idle_H == 1'b1, 320'(idle_H), 320'(1));
    halt_RnnnnL = 1;
    repeat (8) step();
    chk("mid_quiet", tri_count_U == 32'd0, 320'(tri_count_U), 320'(0));

    // continuous streaming of 100 triangles
    t_start = cyc;
    for (int k = 0; k < 100; k++) send(rnd_ent());
    chk("stream_rate", (cyc - t_start) == 100,
        320'(cyc - t_start), 320'(100));
    drain();
    @(negedge clk);
    chk("stream_cnt", tri_count_U == 32'd100,
        320'(tri_count_U), 320'(100));

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
